nes_ppu_pattern_gen: RTL
========================

NES_PPU_PATTERN_GEN -- requirements
Module: nes_ppu_pattern_gen

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per NES pixel tick; legal range 1..16.
REQ-002 Parameter ODD_SKIP, default 1: 1 = shorten odd frames by one dot, as the 2C02 does.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 enable  in  1  1 = generator runs; 0 = position frozen.
REQ-006 mode  in  2  pattern select, sampled at frame boundary: 0 bars, 1 ramp, 2 checker, 3 solid.
REQ-007 solid_color  in  6  palette index used in mode 3.
REQ-008 color  out  6  palette index for the current (scanline, cycle).
REQ-009 cycle  out  9  dot position, 0..340.
REQ-010 scanline  out  9  line position, 0..261.
REQ-011 pix_we  out  1  one-clk strobe: color/cycle/scanline changed to a visible dot.
REQ-012 vblank  out  1  high while scanline is 241..260.
REQ-013 frame_done  out  1  one-clk strobe on wrap to scanline 0.
REQ-014 frame_cnt  out  8  completed-frame count, wraps 255->0.

Function
REQ-015 The divider SHALL count 0..CLK_DIV-1 while enable=1; a tick SHALL occur on the clk where it equals CLK_DIV-1, and the divider SHALL return to 0 there.
REQ-016 With enable=0, the divider SHALL reset to 0 and cycle, scanline, color, frame_cnt and mode_q SHALL hold; pix_we and frame_done SHALL be 0.
REQ-017 On a tick, cycle SHALL increment; at 340 it SHALL go to 0 and scanline SHALL increment; scanline 261 -> 0.
REQ-018 When ODD_SKIP=1 and frame_cnt[0]=1, the tick at (261,339) SHALL go directly to (0,0); dot 340 is skipped.
REQ-019 The wrap to (0,0) SHALL pulse frame_done for exactly one clk, increment frame_cnt, and latch mode into mode_q in the same clk.
REQ-020 color, cycle and scanline SHALL be registered together, and color SHALL correspond to the new position in the same clk, with zero relative latency.
REQ-021 A dot is visible when scanline<240 and cycle<256; non-visible dots SHALL output color 6'h0D.
REQ-022 Mode 0: bar index = cycle[7:5], mapping to 30,28,2C,2A,24,16,12,0D (hex) for indices 0..7.
REQ-023 Mode 1: color = cycle[7:2] (64-step horizontal ramp).
REQ-024 Mode 2: color = 6'h30 when cycle[3]^scanline[3]=1, else 6'h0D.
REQ-025 Mode 3: color = solid_color, sampled live each tick rather than frame-latched.
REQ-026 pix_we SHALL be 1 only in the clk where a tick lands on a visible dot.
REQ-027 vblank SHALL be registered combinationally from the new scanline and SHALL update in the same clk as scanline.
REQ-028 mode changes mid-frame SHALL NOT affect the pattern until the next frame_done.

Reset
REQ-029 While resetn=0 at a clk edge, the following SHALL hold: divider=0, cycle=0, scanline=0, color=6'h0D, pix_we=0, vblank=0, frame_done=0, frame_cnt=0, mode_q=mode.
REQ-030 Reset SHALL take priority over enable and over any in-progress tick; the first tick after release SHALL move to (0,1).

Verification
REQ-031 Reset, enable=1, CLK_DIV=4, mode=0: first tick on 4th clk after release -> cycle=1, scanline=0, color=30, pix_we=1 for one clk only.
REQ-032 Run two full frames with ODD_SKIP=1: frame 0 is 341*262=89342 ticks and frame 1 is 89341 ticks; frame_done fires once each; frame_cnt goes 1, then 2.
REQ-033 Mode 2, scanline 8: cycle 0..7 -> 30, cycle 8..15 -> 0D; at cycle 256 -> 0D with pix_we=0.
REQ-034 Change mode 0->1 at scanline 100: the bars continue until frame_done; line 0 dot 8 of the next frame -> color=02.
REQ-035 Drop enable for 10 clks mid-line at (50,120): outputs hold, no strobes; after re-enable, the next tick comes after CLK_DIV clks -> (50,121).
REQ-036 Assert resetn=0 at (245,300) with vblank=1: next clk -> (0,0), color=0D, vblank=0, frame_cnt=0.

Source files
------------

// File: rtl/nes_ppu_pattern_gen.sv
// NES PPU-style test pattern generator.
// Walks the 341x262 dot raster at one dot per CLK_DIV clocks and produces a
// palette index for each dot. The pattern choice is taken at the frame boundary.
// Odd frames can be shortened by one dot, matching the 2C02.
module nes_ppu_pattern_gen #(
   parameter int CLK_DIV  = 4,
   parameter int ODD_SKIP = 1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       enable,
   input  logic [1:0] mode,
   input  logic [5:0] solid_color,
   output logic [5:0] color,
   output logic [8:0] cycle,
   output logic [8:0] scanline,
   output logic       pix_we,
   output logic       vblank,
   output logic       frame_done,
   output logic [7:0] frame_cnt
);

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [5:0] C_BLANK  = 6'h0D;
   localparam logic [8:0] LAST_DOT  = 9'd340;
   localparam logic [8:0] LAST_LINE = 9'd261;

   logic [3:0] div_q, div_d;
   logic [8:0] cycle_q, cycle_d;
   logic [8:0] scanline_q, scanline_d;
   logic [5:0] color_q, color_d;
   logic       pix_we_q, pix_we_d;
   logic       vblank_q, vblank_d;
   logic       frame_done_q, frame_done_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic [1:0] mode_q, mode_d;

   logic tick;
   logic wrap;
   logic skip_dot;
   logic visible_d;

   // Palette index for a visible dot; blanking is applied by the caller.
   function automatic logic [5:0] pattern_color(input logic [1:0] m,
                                                input logic [8:0] c,
                                                input logic [8:0] s,
                                                input logic [5:0] solid);
      logic [5:0] col;
      col = C_BLANK;
      unique case (m)
         2'd0: begin
            unique case (c[7:5])
               3'd0: col = 6'h30;
               3'd1: col = 6'h28;
               3'd2: col = 6'h2C;
               3'd3: col = 6'h2A;
               3'd4: col = 6'h24;
               3'd5: col = 6'h16;
               3'd6: col = 6'h12;
               3'd7: col = 6'h0D;
               default: col = C_BLANK;
            endcase
         end
         2'd1: col = c[7:2];
         2'd2: col = (c[3] ^ s[3]) ? 6'h30 : C_BLANK;
         2'd3: col = solid;
         default: col = C_BLANK;
      endcase
      return col;
   endfunction

   assign tick     = enable && (div_q == DIV_LAST);
   // Odd frames jump from (261,339) straight to (0,0).
   assign skip_dot = (ODD_SKIP != 0) && frame_cnt_q[0] &&
                     (scanline_q == LAST_LINE) && (cycle_q == 9'd339);

   // Divider and raster position advance; frame wrap bookkeeping.
   always_comb begin
      div_d       = div_q;
      cycle_d     = cycle_q;
      scanline_d  = scanline_q;
      frame_cnt_d = frame_cnt_q;
      mode_d      = mode_q;
      wrap        = 1'b0;
      if (!enable || tick) begin
         div_d = 4'd0;
      end else begin
         div_d = div_q + 4'd1;
      end
      if (tick) begin
         if (skip_dot || (cycle_q == LAST_DOT && scanline_q == LAST_LINE)) begin
            wrap        = 1'b1;
            cycle_d     = 9'd0;
            scanline_d  = 9'd0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            mode_d      = mode;
         end else if (cycle_q == LAST_DOT) begin
            cycle_d    = 9'd0;
            scanline_d = scanline_q + 9'd1;
         end else begin
            cycle_d = cycle_q + 9'd1;
         end
      end
   end

   // Color, strobes and vblank derived from the new position so they land with it.
   always_comb begin
      color_d      = color_q;
      vblank_d     = vblank_q;
      pix_we_d     = 1'b0;
      frame_done_d = 1'b0;
      visible_d    = (scanline_d < 9'd240) && (cycle_d < 9'd256);
      if (tick) begin
         color_d      = visible_d ? pattern_color(mode_d, cycle_d, scanline_d, solid_color)
                                  : C_BLANK;
         vblank_d     = (scanline_d >= 9'd241) && (scanline_d <= 9'd260);
         pix_we_d     = visible_d;
         frame_done_d = wrap;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         div_q        <= 4'd0;
         cycle_q      <= 9'd0;
         scanline_q   <= 9'd0;
         color_q      <= C_BLANK;
         pix_we_q     <= 1'b0;
         vblank_q     <= 1'b0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= 8'd0;
         mode_q       <= mode;
      end else begin
         div_q        <= div_d;
         cycle_q      <= cycle_d;
         scanline_q   <= scanline_d;
         color_q      <= color_d;
         pix_we_q     <= pix_we_d;
         vblank_q     <= vblank_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
         mode_q       <= mode_d;
      end
   end

   assign color      = color_q;
   assign cycle      = cycle_q;
   assign scanline   = scanline_q;
   assign pix_we     = pix_we_q;
   assign vblank     = vblank_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;

endmodule
